// File: rtl/bird_datapath.sv
// Bird vertical-position datapath: once per frame tick it erases the sprite, applies the latched
// movement, redraws it as a registered pixel stream, and reports the too-high flag and ground contact.
module bird_datapath #(
  parameter int         X_POS       = 20,
  parameter int         Y_INIT      = 60,
  parameter int         SIZE        = 4,
  parameter int         Y_MAX       = 120,
  parameter int         TICK_CYCLES = 833333,
  parameter int         RISE_STEP   = 2,
  parameter int         FALL_STEP   = 1,
  parameter int         RISE_LIMIT  = 8,
  parameter logic [2:0] BIRD_COLOUR = 3'b110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] current,
  output logic       flag,
  output logic       on_ground,
  output logic [6:0] bird_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       frame_done
);
  localparam int LOG_S = $clog2(SIZE);
  localparam int PW    = 2 * LOG_S;
  localparam int TW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int RW    = $clog2(RISE_LIMIT + 1);
  localparam logic [6:0]    Y_LOW  = 7'(Y_MAX - SIZE);
  localparam logic [PW-1:0] P_LAST = '1;

  typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} st_e;
  typedef enum logic [1:0] {MV_START, MV_RAISE, MV_FALL, MV_STOP} mv_e;

  st_e           state_q, state_d;
  mv_e           last_mv_q, last_mv_d;
  logic [6:0]    bird_y_q, bird_y_d, mv_y;
  logic [RW-1:0] rise_cnt_q, rise_cnt_d, mv_rc;
  logic [TW-1:0] tick_q, tick_d;
  logic [PW-1:0] p_q, p_d;
  logic [7:0]    x_q, x_d, fall_sum;
  logic [6:0]    y_q, y_d;
  logic [2:0]    colour_q, colour_d;
  logic          plot_q, plot_d, done_q, done_d, tick;

  function automatic logic [7:0] pix_x(input logic [PW-1:0] p);
    return 8'(X_POS) + 8'(p[LOG_S-1:0]);
  endfunction

  function automatic logic [6:0] pix_y(input logic [6:0] yb, input logic [PW-1:0] p);
    return yb + 7'(p[PW-1:LOG_S]);
  endfunction

  // DRAW codes and illegal codes keep the previous movement so alternating DRAW cycles are transparent
  always_comb begin
    last_mv_d = last_mv_q;
    if (current[3:2] == 2'b00) last_mv_d = mv_e'(current[1:0]);
    tick   = (tick_q == TW'(TICK_CYCLES - 1));
    tick_d = tick ? '0 : tick_q + TW'(1);
  end

  always_comb begin
    mv_y     = bird_y_q;
    mv_rc    = rise_cnt_q;
    fall_sum = {1'b0, bird_y_q} + 8'(FALL_STEP);
    case (last_mv_q)
      MV_START: begin
        mv_y  = 7'(Y_INIT);
        mv_rc = '0;
      end
      MV_RAISE: begin
        mv_y = (bird_y_q >= 7'(RISE_STEP)) ? bird_y_q - 7'(RISE_STEP) : '0;
        if (rise_cnt_q < RW'(RISE_LIMIT)) mv_rc = rise_cnt_q + RW'(1);
      end
      MV_FALL: begin
        mv_y  = (fall_sum > {1'b0, Y_LOW}) ? Y_LOW : fall_sum[6:0];
        mv_rc = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    bird_y_d   = bird_y_q;
    rise_cnt_d = rise_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d  = ERASE;
          p_d      = '0;
          plot_d   = 1'b1;
          colour_d = 3'b000;
          x_d      = pix_x('0);
          y_d      = bird_y_q;
        end
      end
      ERASE: begin
        if (p_q == P_LAST) begin
          state_d = UPDATE;
        end else begin
          p_d    = p_q + PW'(1);
          plot_d = 1'b1;
          x_d    = pix_x(p_d);
          y_d    = pix_y(bird_y_q, p_d);
        end
      end
      UPDATE: begin
        // First draw pixel is addressed from the freshly moved position
        bird_y_d   = mv_y;
        rise_cnt_d = mv_rc;
        state_d    = DRAW;
        p_d        = '0;
        plot_d     = 1'b1;
        colour_d   = BIRD_COLOUR;
        x_d        = pix_x('0);
        y_d        = mv_y;
      end
      DRAW: begin
        if (p_q == P_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          p_d    = p_q + PW'(1);
          plot_d = 1'b1;
          x_d    = pix_x(p_d);
          y_d    = pix_y(bird_y_q, p_d);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_mv_q  <= MV_START;
      bird_y_q   <= 7'(Y_INIT);
      rise_cnt_q <= '0;
      tick_q     <= '0;
      p_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_mv_q  <= last_mv_d;
      bird_y_q   <= bird_y_d;
      rise_cnt_q <= rise_cnt_d;
      tick_q     <= tick_d;
      p_q        <= p_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      done_q     <= done_d;
    end
  end

  assign flag       = (rise_cnt_q == RW'(RISE_LIMIT)) || (bird_y_q == 7'd0);
  assign on_ground  = (bird_y_q == Y_LOW);
  assign bird_y     = bird_y_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign frame_done = done_q;
endmodule
